// File: rtl/watch_mod_counter.sv
// Modulo-(MAX+1) counter stage for the watch seconds/minutes/hours chain.
// Provides a registered count, a one-cycle wrap carry and a wrap-toggled square wave.
module watch_mod_counter #(
    parameter int WIDTH      = 6,
    parameter int MAX        = 59,
    parameter bit RST_TOGGLE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             carry_o,
    output logic             toggle_o
);

    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX);
    // Terminal value of the widened increment; holds 2**WIDTH when MAX is all ones.
    localparam logic [WIDTH:0]   TERM_EXT = (WIDTH+1)'(MAX + 1);

    // Saturating load: values above the terminal count load the terminal count.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if (val > MAX_C) begin
            res = MAX_C;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             r_toggle;

    logic             w_advance;
    logic [WIDTH:0]   w_inc_ext;
    logic             w_at_max;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_carry_nxt;
    logic             w_toggle_nxt;

    assign w_advance = en_i | inc_i;
    assign w_inc_ext = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign w_at_max  = (w_inc_ext == TERM_EXT);

    // Next-state selection: clear, then load, then wrap, then step, else hold.
    always_comb begin
        w_count_nxt  = r_count;
        w_carry_nxt  = 1'b0;
        w_toggle_nxt = r_toggle;
        if (clr_i) begin
            w_count_nxt = {WIDTH{1'b0}};
        end else if (load_i) begin
            w_count_nxt = sat_load(load_val_i);
        end else if (w_advance && w_at_max) begin
            w_count_nxt  = {WIDTH{1'b0}};
            w_carry_nxt  = 1'b1;
            w_toggle_nxt = ~r_toggle;
        end else if (w_advance) begin
            w_count_nxt = w_inc_ext[WIDTH-1:0];
        end else begin
            w_count_nxt = r_count;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count  <= {WIDTH{1'b0}};
            r_carry  <= 1'b0;
            r_toggle <= RST_TOGGLE;
        end else begin
            r_count  <= w_count_nxt;
            r_carry  <= w_carry_nxt;
            r_toggle <= w_toggle_nxt;
        end
    end

    assign count_o  = r_count;
    assign carry_o  = r_carry;
    assign toggle_o = r_toggle;

endmodule

// File: tb/tb_watch_mod_counter.sv
// Directed bench for watch_mod_counter: a MAX=59 stage and a MAX=14 stage on one clock.
module tb_watch_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, inc, clr, load;
    logic [5:0] lv;
    logic [5:0] cnt;
    logic       car, tog;

    logic       en14, inc14, clr14, load14;
    logic [3:0] lv14;
    logic [3:0] cnt14;
    logic       car14, tog14;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    watch_mod_counter #(.WIDTH(6), .MAX(59), .RST_TOGGLE(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .clr_i(clr), .load_i(load),
        .load_val_i(lv), .inc_i(inc), .count_o(cnt), .carry_o(car), .toggle_o(tog)
    );

    watch_mod_counter #(.WIDTH(4), .MAX(14), .RST_TOGGLE(1'b1)) dut14 (
        .clk_i(clk), .rst_i(rst_n), .en_i(en14), .clr_i(clr14), .load_i(load14),
        .load_val_i(lv14), .inc_i(inc14), .count_o(cnt14), .carry_o(car14), .toggle_o(tog14)
    );

    typedef struct {
        logic       en;
        logic       inc;
        logic       clr;
        logic       load;
        logic [5:0] lv;
        logic [5:0] ec;
        logic       ecar;
        logic       etog;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string nm, input int c, input int ca, input int t);
        chk({nm, ".count"},  {26'd0, cnt}, c);
        chk({nm, ".carry"},  {31'd0, car}, ca);
        chk({nm, ".toggle"}, {31'd0, tog}, t);
    endtask

    initial begin
        // state entering the table: count 0, toggle 1
        //          en    inc   clr   load  lv     count  carry toggle
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd1,  1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  6'd2,  1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd2,  1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'd3,  1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd45, 6'd45, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd46, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 6'd59, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd59, 6'd59, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd10, 6'd0,  1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd59, 6'd59, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 6'd10, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd60, 6'd59, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'd1,  1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd58, 6'd58, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  6'd59, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd1,  1'b0, 1'b1};

        rst_n = 1'b0;
        en = 1'b0; inc = 1'b0; clr = 1'b0; load = 1'b0; lv = 6'd0;
        en14 = 1'b0; inc14 = 1'b0; clr14 = 1'b0; load14 = 1'b0; lv14 = 4'd0;
        #12;
        chk3("reset", 0, 0, 1);
        chk("reset14.count", {28'd0, cnt14}, 0);
        chk("reset14.toggle", {31'd0, tog14}, 1);
        rst_n = 1'b1;

        // Free run: MAX=59 for two wraps, MAX=14 alongside for 60 clocks
        en = 1'b1;
        en14 = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            tick();
            chk3("run59", k % 60, (k % 60 == 0) ? 1 : 0, ((k / 60) % 2 == 0) ? 1 : 0);
            if (k <= 60) begin
                chk("run14.count", {28'd0, cnt14}, k % 15);
                chk("run14.carry", {31'd0, car14}, (k % 15 == 0) ? 1 : 0);
                chk("run14.toggle", {31'd0, tog14}, ((k / 15) % 2 == 0) ? 1 : 0);
            end
            if (k == 60) en14 = 1'b0;
        end
        en = 1'b0;

        // Table-driven priority, load saturation and combined-advance vectors
        for (int i = 0; i < 20; i++) begin
            en = tbl[i].en; inc = tbl[i].inc; clr = tbl[i].clr;
            load = tbl[i].load; lv = tbl[i].lv;
            tick();
            chk3($sformatf("vec%0d", i), int'(tbl[i].ec), int'(tbl[i].ecar), int'(tbl[i].etog));
        end
        en = 1'b0; inc = 1'b0; clr = 1'b0; load = 1'b0;

        // en and inc together advance once per clock
        clr = 1'b1; tick(); clr = 1'b0;
        chk3("clr", 0, 0, 1);
        en = 1'b1; inc = 1'b1;
        repeat (5) tick();
        en = 1'b0; inc = 1'b0;
        chk3("en_inc5", 5, 0, 1);

        // Three isolated manual-advance pulses
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (3) begin
            inc = 1'b1; tick();
            inc = 1'b0; tick();
        end
        chk3("inc3", 3, 0, 1);

        // Wrap once so toggle differs from its reset value, then count to 33
        load = 1'b1; lv = 6'd59; tick(); load = 1'b0;
        en = 1'b1; tick();
        chk3("prewrap", 0, 1, 0);
        repeat (33) tick();
        chk3("at33", 33, 0, 0);

        // Asynchronous reset between edges, held with en high, then released
        #3 rst_n = 1'b0;
        #1 chk3("async_rst", 0, 0, 1);
        repeat (3) begin
            tick();
            chk3("rst_hold", 0, 0, 1);
        end
        #3 rst_n = 1'b1;
        tick();
        chk3("post_rst", 1, 0, 1);
        tick();
        chk3("post_rst2", 2, 0, 1);
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_mod_counter.md
# watch_mod_counter

Parametrised modulo-(MAX+1) counter used for the watch's seconds, minutes and hours chains. It counts ticks of the slow watch clock and exposes the current count for display. It produces a one-cycle carry pulse to cascade into the next stage and a toggling square-wave output. Compared with the fixed 0–14 toggle divider, it adds a configurable width and terminal count, a count enable, a synchronous clear, a load path for setting the time, and a manual-advance input for the set buttons.

## Interface

Parameters:
- WIDTH, default 6: width of the count register.
- MAX, default 59: terminal count. The counter runs 0..MAX. Legal range is 1 ≤ MAX ≤ 2**WIDTH−1.
- RST_TOGGLE, default 1: reset value of toggle_o.

Ports:
- clk_i, input, 1: stage clock. This is the 1 Hz watch clock, or the upstream stage clock.
- rst_i, input, 1: reset. Asynchronous and active-low; it clears all state immediately on assertion.
- en_i, input, 1: count enable. One advance per clock while high.
- clr_i, input, 1: synchronous clear to 0.
- load_i, input, 1: synchronous load of load_val_i.
- load_val_i, input, WIDTH: value to load.
- inc_i, input, 1: manual advance, used for time setting. It acts independently of en_i.
- count_o, output, WIDTH: current count (registered).
- carry_o, output, 1: registered one-cycle pulse on wrap MAX→0.
- toggle_o, output, 1: registered output that inverts on every wrap. Its period is 2·(MAX+1) clocks.

## Operation

- Reset (rst_i=0):
  - count_o=0
  - carry_o=0
  - toggle_o=RST_TOGGLE
  - These values hold for as long as rst_i=0.
  - An assertion mid-count discards all state; there is no partial update.
- Define advance = en_i OR inc_i. When both are high in the same cycle, the counter advances by exactly one step, not two.
- Per-edge priority, highest first:
  1. clr_i=1: count←0; carry←0; toggle unchanged.
  2. load_i=1: count←min(load_val_i, MAX); carry←0; toggle unchanged.
  3. advance=1 and count=MAX: count←0; carry←1; toggle←~toggle.
  4. advance=1 and count<MAX: count←count+1; carry←0.
  5. Otherwise: count holds; carry←0.
- Load saturation: a load_val_i above MAX loads MAX. Out-of-range counts are therefore unreachable.
- Clear and load never generate a carry or a toggle, even when the count was MAX.
- carry_o is high for exactly one cycle per wrap. It coincides with the first cycle in which count_o=0.
- Cascading: feed carry_o into the next stage's en_i, using the same clk_i. The chain is then fully synchronous.
- Arithmetic is unsigned. The increment is computed at WIDTH+1 bits, so count never overflows the register.
- When MAX=2**WIDTH−1, the wrap is still an explicit compare. It does not rely on natural overflow.

## Timing

- Every output is registered and changes only on the rising edge of clk_i or on rst_i assertion. There are no combinational paths from input to output.
- Latency from en_i/inc_i/clr_i/load_i to count_o is one clock.
- Wrap timing: if count_o=MAX and advance=1 in cycle N, then in cycle N+1 count_o=0, carry_o=1 and toggle_o is inverted. In cycle N+2, carry_o=0 unless MAX… (MAX ≥ 1 guarantees no back-to-back carries).
- The minimum spacing between carry pulses is MAX+1 clocks.
- On rst_i deassertion, the first active edge may already advance the counter. Synchronous deassertion is handled at the top level.

## Test plan

- Reset with WIDTH=6, MAX=59, en_i=1 held for 60 clocks → count_o steps 0..59. On the 60th edge: count_o=0, carry_o=1 for one cycle, toggle_o goes 1→0. A second wrap 60 clocks later sets toggle_o=1.
- WIDTH=4, MAX=14, en_i=1 for 60 clocks → carry_o pulses at clocks 15, 30, 45 and 60. toggle_o has a period of 30 clocks, with its first fall at clock 15.
- Load 45, then en_i=1 → count_o=45 with no carry, then 46…59, 0 with a carry. Load 63 with MAX=59 → count_o=59.
- count_o=59, and clr_i=1 together with load_i=1 and en_i=1 → count_o=0, carry_o=0, toggle_o unchanged. With load_i=1 and en_i=1 only, load_val_i=10 → count_o=10, no carry.
- en_i=1 and inc_i=1 for 5 clocks from 0 → count_o=5, not 10. With en_i=0 and inc_i pulsed 3 times → count_o=3.
- Mid-count reset: pull rst_i low asynchronously at count_o=33, between edges → outputs immediately read 0/0/RST_TOGGLE. They hold while rst_i=0 regardless of en_i, and counting restarts from 0 after release.
